// File: rtl/text_console_writer.sv
// text_console_writer
// Turns a stream of character codes into byte-masked writes to an 80x30
// write-only text screenbuffer. Tracks the cursor, interprets CR, LF, BS
// and FF, and clears each newly entered line so the screen wraps around
// without reading VRAM back.
//
// Handshake semantics (both sides):
//   Upstream: a character transfers on a rising edge where in_valid and
//   in_ready are both high. in_ready is high only in IDLE and is low while
//   reset is asserted. The upstream holds in_data until it is taken.
//   Bus: wen rises the cycle after a write is decided. addr, wdata and
//   wmask stay constant while wen is high. A write completes on a rising
//   edge where wen and bus_ready are both high. wen is then low for at
//   least one cycle before the next write. There is no timeout.
module text_console_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000,
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic        wen,
    input  logic        bus_ready,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Word clears address the buffer in 4-byte steps, so a row must be a
    // whole number of words.
    if ((COLS % 4) != 0) begin : g_cols_check
        $error("text_console_writer: COLS must be a multiple of 4");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        CLR_LINE = 2'd2,
        CLR_ALL  = 2'd3
    } state_e;

    localparam logic [6:0]  LAST_COL          = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW          = 5'(ROWS - 1);
    localparam logic [11:0] COLS_W            = 12'(COLS);
    localparam logic [9:0]  LINE_WORDS_LAST   = 10'(COLS / 4 - 1);
    localparam logic [9:0]  SCREEN_WORDS_LAST = 10'(ROWS * COLS / 4 - 1);
    localparam logic [31:0] FILL_WORD         = {4{FILL_CHAR}};

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [9:0]  word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        wen_q, wen_d;
    logic        in_ready_q, in_ready_d;

    logic        accept;
    logic        bus_done;
    logic        is_print;
    logic        is_cr;
    logic        is_lf;
    logic        is_bs;
    logic        is_ff;
    logic        at_last_col;
    logic        last_word;
    logic [4:0]  next_row;
    logic [11:0] line_base;
    logic [11:0] cursor_idx;
    logic [11:0] clr_idx;
    logic [31:0] print_addr;
    logic [31:0] clr_addr;

    // Decode the incoming character and precompute cursor/clear addresses.
    always_comb begin
        accept      = in_ready_q & in_valid;
        bus_done    = wen_q & bus_ready;
        is_print    = ((in_data >= 8'h20) && (in_data <= 8'h7E)) || in_data[7];
        is_cr       = (in_data == 8'h0D);
        is_lf       = (in_data == 8'h0A);
        is_bs       = (in_data == 8'h08);
        is_ff       = (in_data == 8'h0C);
        at_last_col = (col_q == LAST_COL);
        next_row    = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
        line_base   = {7'd0, row_q} * COLS_W;
        cursor_idx  = line_base + {5'd0, col_q};
        if (state_q == CLR_ALL) begin
            clr_idx   = {word_q, 2'b00};
            last_word = (word_q == SCREEN_WORDS_LAST);
        end else begin
            clr_idx   = line_base + {word_q, 2'b00};
            last_word = (word_q == LINE_WORDS_LAST);
        end
        print_addr = BASE_ADDR + {20'd0, cursor_idx};
        clr_addr   = BASE_ADDR + {20'd0, clr_idx};
    end

    // State and datapath registers; reset drops wen immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            col_q      <= 7'd0;
            row_q      <= 5'd0;
            word_q     <= 10'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'd0;
            wen_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            wen_q      <= wen_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        state_d = WRITE;
                    end else if (is_lf) begin
                        state_d = CLR_LINE;
                    end else if (is_ff) begin
                        state_d = CLR_ALL;
                    end
                end
            end
            WRITE: begin
                if (bus_done) begin
                    state_d = at_last_col ? CLR_LINE : IDLE;
                end
            end
            CLR_LINE, CLR_ALL: begin
                if (bus_done && last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cursor, word counter and bus request updates.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        wen_d      = wen_q;
        in_ready_d = (state_d == IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        addr_d  = print_addr;
                        wmask_d = 4'b0001 << print_addr[1:0];
                        wdata_d = {4{in_data}};
                        wen_d   = 1'b1;
                    end else if (is_cr) begin
                        col_d = 7'd0;
                    end else if (is_lf) begin
                        col_d  = 7'd0;
                        row_d  = next_row;
                        word_d = 10'd0;
                    end else if (is_bs) begin
                        if (col_q != 7'd0) begin
                            col_d = col_q - 7'd1;
                        end
                    end else if (is_ff) begin
                        col_d  = 7'd0;
                        row_d  = 5'd0;
                        word_d = 10'd0;
                    end
                end
            end
            WRITE: begin
                if (bus_done) begin
                    wen_d = 1'b0;
                    if (at_last_col) begin
                        col_d  = 7'd0;
                        row_d  = next_row;
                        word_d = 10'd0;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            CLR_LINE, CLR_ALL: begin
                if (bus_done) begin
                    wen_d  = 1'b0;
                    word_d = last_word ? 10'd0 : word_q + 10'd1;
                end else if (!wen_q) begin
                    // The idle cycle after each completion issues the next word.
                    addr_d  = clr_addr;
                    wdata_d = FILL_WORD;
                    wmask_d = 4'b1111;
                    wen_d   = 1'b1;
                end
            end
            default: begin
                wen_d = 1'b0;
            end
        endcase
    end

    assign in_ready   = in_ready_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign wmask      = wmask_q;
    assign wen        = wen_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: randomized character streams against a
// screen-level reference model, with a bus responder acting as slave.
`timescale 1ns/1ps
module tb_text_console_writer;

    localparam logic [31:0] BASE = 32'h8000;
    localparam int          COLS = 80;
    localparam int          ROWS = 30;
    localparam logic [7:0]  FILL = 8'h20;

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        bus_ready = 1'b0;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    text_console_writer #(
        .BASE_ADDR (BASE),
        .COLS      (COLS),
        .ROWS      (ROWS),
        .FILL_CHAR (FILL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr       (addr),
        .wdata      (wdata),
        .wmask      (wmask),
        .wen        (wen),
        .bus_ready  (bus_ready),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Counters and scoreboard state
    int total = 0;
    int bad   = 0;
    logic [67:0] exp_q[$];
    int mcol = 0;
    int mrow = 0;

    int          ready_delay = 0;
    bit          rand_delay  = 1'b0;
    int          n_writes    = 0;
    int          wen_hi_cnt  = 0;
    int          busy_ready_viol = 0;
    logic [31:0] last_addr  = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    logic [3:0]  last_wmask = 4'd0;

    // Reference model: screen-level behaviour
    function automatic void model_newline();
        mrow = (mrow + 1) % ROWS;
        for (int k = 0; k < COLS / 4; k++) begin
            exp_q.push_back({BASE + 32'(mrow * COLS + 4 * k), {4{FILL}}, 4'hF});
        end
    endfunction

    function automatic void model_char(input logic [7:0] c);
        logic [31:0] a;
        logic [3:0]  m;
        if ((c >= 8'h20 && c <= 8'h7E) || c >= 8'h80) begin
            a = BASE + 32'(mrow * COLS + mcol);
            m = 4'(1 << (a % 4));
            exp_q.push_back({a, {4{c}}, m});
            if (mcol < COLS - 1) begin
                mcol++;
            end else begin
                mcol = 0;
                model_newline();
            end
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            mcol = 0;
            model_newline();
        end else if (c == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'h0C) begin
            mcol = 0;
            mrow = 0;
            for (int i = 0; i < ROWS * COLS / 4; i++) begin
                exp_q.push_back({BASE + 32'(4 * i), {4{FILL}}, 4'hF});
            end
        end
    endfunction

    // Bus slave: drives bus_ready, checks hold stability, gap and scoreboard
    task automatic bus_responder();
        int          wait_cnt = 0;
        int          cur_delay = 0;
        bit          prev_done = 1'b0;
        logic [67:0] hold;
        logic [67:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus_ready = 1'b0;
                wait_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy && in_ready) busy_ready_viol++;
                if (prev_done) begin
                    total++;
                    if (wen !== 1'b0) begin
                        bad++;
                        $display("FAIL wen_gap: wen=%b after completion, expected 0", wen);
                    end
                end
                prev_done = 1'b0;
                bus_ready = 1'b0;
                if (wen === 1'b1) begin
                    wen_hi_cnt++;
                    if (wait_cnt == 0) begin
                        hold = {addr, wdata, wmask};
                        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : ready_delay;
                    end else begin
                        total++;
                        if ({addr, wdata, wmask} !== hold) begin
                            bad++;
                            $display("FAIL hold_stable: got %h expected %h", {addr, wdata, wmask}, hold);
                        end
                    end
                    if (wait_cnt >= cur_delay) begin
                        bus_ready  = 1'b1;
                        prev_done  = 1'b1;
                        wait_cnt   = 0;
                        n_writes++;
                        last_addr  = addr;
                        last_wdata = wdata;
                        last_wmask = wmask;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_write: addr=%h wdata=%h wmask=%b, expected none", addr, wdata, wmask);
                        end else begin
                            e = exp_q.pop_front();
                            if ({addr, wdata, wmask} !== e) begin
                                bad++;
                                $display("FAIL write: addr=%h wdata=%h wmask=%b expected addr=%h wdata=%h wmask=%b",
                                         addr, wdata, wmask, e[67:36], e[35:4], e[3:0]);
                            end
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
            return;
        end
        in_data  = c;
        in_valid = 1'b1;
        model_char(c);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || !in_ready) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy || !in_ready) begin
            bad++;
            $display("FAIL %s_idle_timeout: busy=%b in_ready=%b, expected 0/1", tag, busy, in_ready);
        end
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (wen !== 1'b0 || addr !== 32'd0 || wdata !== 32'd0 || wmask !== 4'd0) begin
            bad++;
            $display("FAIL reset_bus: wen=%b addr=%h wdata=%h wmask=%b, expected all 0", wen, addr, wdata, wmask);
        end
        total++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL reset_cursor: (%0d,%0d) expected (0,0)", cursor_col, cursor_row);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%b busy=%b expected 0/0", in_ready, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        mcol = 0;
        mrow = 0;
    endtask

    task automatic test_single_char();
        int n0;
        int h0;
        do_reset();
        rand_delay  = 1'b0;
        ready_delay = 0;
        n0 = n_writes;
        h0 = wen_hi_cnt;
        send_char(8'h41);
        wait_idle("single");
        repeat (2) @(negedge clk);
        total++;
        if (n_writes - n0 != 1) begin
            bad++;
            $display("FAIL single_count: %0d writes expected 1", n_writes - n0);
        end
        total++;
        if (last_addr !== 32'h8000 || last_wdata !== 32'h41414141 || last_wmask !== 4'b0001) begin
            bad++;
            $display("FAIL single_write: addr=%h wdata=%h wmask=%b expected 8000/41414141/0001", last_addr, last_wdata, last_wmask);
        end
        total++;
        if (wen_hi_cnt - h0 != 1) begin
            bad++;
            $display("FAIL single_wen_width: %0d cycles expected 1", wen_hi_cnt - h0);
        end
        total++;
        if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL single_cursor: (%0d,%0d) expected (1,0)", cursor_col, cursor_row);
        end
    endtask

    task automatic test_bus_wait();
        logic [7:0] str [5];
        int h0;
        str = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        do_reset();
        rand_delay  = 1'b0;
        ready_delay = 3;
        h0 = wen_hi_cnt;
        for (int i = 0; i < 5; i++) send_char(str[i]);
        wait_idle("bus_wait");
        total++;
        if (last_addr !== 32'h8004 || last_wmask !== 4'b0001 || last_wdata !== 32'h45454545) begin
            bad++;
            $display("FAIL bus_wait_last: addr=%h wmask=%b wdata=%h expected 8004/0001/45454545", last_addr, last_wmask, last_wdata);
        end
        total++;
        if (wen_hi_cnt - h0 != 20) begin
            bad++;
            $display("FAIL bus_wait_wen_cycles: %0d expected 20", wen_hi_cnt - h0);
        end
        total++;
        if (cursor_col !== 7'd5 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL bus_wait_cursor: (%0d,%0d) expected (5,0)", cursor_col, cursor_row);
        end
    endtask

    task automatic test_line_wrap();
        int n0;
        int v0;
        int n = 0;
        logic [7:0] c;
        do_reset();
        rand_delay = 1'b1;
        n0 = n_writes;
        v0 = busy_ready_viol;
        for (int i = 0; i < COLS; i++) begin
            c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(128, 255));
            send_char(c);
        end
        while (n_writes < n0 + COLS + 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL wrap_clear_ready: busy=%b in_ready=%b expected 1/0", busy, in_ready);
        end
        wait_idle("wrap");
        total++;
        if (n_writes - n0 != COLS + COLS / 4) begin
            bad++;
            $display("FAIL wrap_count: %0d writes expected %0d", n_writes - n0, COLS + COLS / 4);
        end
        total++;
        if (last_addr !== 32'h809C || last_wmask !== 4'b1111 || last_wdata !== 32'h20202020) begin
            bad++;
            $display("FAIL wrap_last_clear: addr=%h wmask=%b wdata=%h expected 809C/1111/20202020", last_addr, last_wmask, last_wdata);
        end
        total++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
            bad++;
            $display("FAIL wrap_cursor: (%0d,%0d) expected (0,1)", cursor_col, cursor_row);
        end
        total++;
        if (busy_ready_viol != v0) begin
            bad++;
            $display("FAIL wrap_ready_while_busy: %0d cycles expected 0", busy_ready_viol - v0);
        end
    endtask

    task automatic test_row_wrap();
        int n0;
        do_reset();
        rand_delay  = 1'b0;
        ready_delay = 0;
        for (int i = 0; i < ROWS - 1; i++) send_char(8'h0A);
        wait_idle("row29");
        send_char(8'h61);
        send_char(8'h62);
        wait_idle("row29_chars");
        total++;
        if (cursor_col !== 7'd2 || cursor_row !== 5'd29) begin
            bad++;
            $display("FAIL row29_cursor: (%0d,%0d) expected (2,29)", cursor_col, cursor_row);
        end
        n0 = n_writes;
        send_char(8'h0A);
        wait_idle("row_wrap");
        total++;
        if (n_writes - n0 != COLS / 4 || last_addr !== 32'h804C) begin
            bad++;
            $display("FAIL row_wrap_clear: %0d writes last=%h expected 20 last=804C", n_writes - n0, last_addr);
        end
        total++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL row_wrap_cursor: (%0d,%0d) expected (0,0)", cursor_col, cursor_row);
        end
    endtask

    task automatic test_backspace_cr();
        int n0;
        do_reset();
        rand_delay  = 1'b0;
        ready_delay = 1;
        send_char(8'h58);
        send_char(8'h08);
        send_char(8'h08);
        wait_idle("bs");
        total++;
        if (cursor_col !== 7'd0) begin
            bad++;
            $display("FAIL bs_at_zero: col=%0d expected 0", cursor_col);
        end
        send_char(8'h59);
        wait_idle("bs_y");
        total++;
        if (last_addr !== 32'h8000 || last_wmask !== 4'b0001 || last_wdata !== 32'h59595959) begin
            bad++;
            $display("FAIL bs_overwrite: addr=%h wmask=%b wdata=%h expected 8000/0001/59595959", last_addr, last_wmask, last_wdata);
        end
        for (int i = 0; i < 4; i++) send_char(8'h30 + 8'(i));
        wait_idle("cr_fill");
        total++;
        if (cursor_col !== 7'd5) begin
            bad++;
            $display("FAIL cr_pre: col=%0d expected 5", cursor_col);
        end
        n0 = n_writes;
        send_char(8'h0D);
        repeat (4) @(negedge clk);
        total++;
        if (n_writes != n0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL cr: writes=%0d cursor=(%0d,%0d) expected 0 writes (0,0)", n_writes - n0, cursor_col, cursor_row);
        end
    endtask

    task automatic test_random();
        logic [7:0] ctl [8];
        logic [7:0] c;
        int sel;
        ctl = '{8'h0D, 8'h0A, 8'h08, 8'h00, 8'h7F, 8'h1B, 8'h09, 8'h08};
        do_reset();
        rand_delay = 1'b1;
        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 1)       c = 8'h0C;
            else if (sel < 35) c = ctl[$urandom_range(0, 7)];
            else               c = 8'($urandom_range(32, 255));
            send_char(c);
            wait_idle("random");
            total++;
            if (cursor_col !== 7'(mcol) || cursor_row !== 5'(mrow)) begin
                bad++;
                $display("FAIL random_cursor: char=%h (%0d,%0d) expected (%0d,%0d)", c, cursor_col, cursor_row, mcol, mrow);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_pending: %0d writes outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_ff_and_reset();
        int n0;
        int n = 0;
        do_reset();
        rand_delay  = 1'b0;
        ready_delay = 0;
        send_char(8'h48);
        send_char(8'h0A);
        send_char(8'h49);
        wait_idle("ff_pre");
        n0 = n_writes;
        send_char(8'h0C);
        total++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ff_accept: cursor=(%0d,%0d) busy=%b expected (0,0) 1", cursor_col, cursor_row, busy);
        end
        wait_idle("ff");
        total++;
        if (n_writes - n0 != ROWS * COLS / 4 || last_addr !== 32'h895C || last_wmask !== 4'hF) begin
            bad++;
            $display("FAIL ff_clear: %0d writes last=%h mask=%b expected 600 895C 1111", n_writes - n0, last_addr, last_wmask);
        end
        // Reset in the middle of the 300th clear word
        send_char(8'h4B);
        wait_idle("ff2_pre");
        ready_delay = 3;
        n0 = n_writes;
        send_char(8'h0C);
        while (!(n_writes == n0 + 299 && wen === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(n_writes == n0 + 299 && wen === 1'b1)) begin
            bad++;
            $display("FAIL ff_reach_300: writes=%0d wen=%b expected 299 done and wen=1", n_writes - n0, wen);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (wen !== 1'b0 || addr !== 32'd0 || wmask !== 4'd0) begin
            bad++;
            $display("FAIL async_reset_bus: wen=%b addr=%h wmask=%b expected 0", wen, addr, wmask);
        end
        total++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_state: cursor=(%0d,%0d) busy=%b in_ready=%b expected (0,0) 0 0",
                     cursor_col, cursor_row, busy, in_ready);
        end
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ready_delay = 0;
        repeat (4) @(negedge clk);
        total++;
        if (n_writes != n0 + 299 || wen !== 1'b0) begin
            bad++;
            $display("FAIL no_retry: writes=%0d wen=%b expected 299 0", n_writes - n0, wen);
        end
        send_char(8'h5A);
        wait_idle("post_reset");
        total++;
        if (last_addr !== 32'h8000 || cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL post_reset_write: addr=%h cursor=(%0d,%0d) expected 8000 (1,0)", last_addr, cursor_col, cursor_row);
        end
    endtask

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        fork
            bus_responder();
        join_none
        test_reset();
        test_single_char();
        test_bus_wait();
        test_line_wrap();
        test_row_wrap();
        test_backspace_cr();
        test_random();
        test_ff_and_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_pending: %0d writes outstanding expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Bus-master stage directly upstream of the text-mode GPU. Turns a byte stream of character codes, from a UART RX or CPU FIFO, into byte-masked writes to the 80x30 screenbuffer.
- Tracks the cursor and handles CR, LF, BS and FF.
- Clears each newly entered line, which gives wrap-around "scrolling" without reading VRAM. The screenbuffer is write-only.

Parameters:
- BASE_ADDR, 32'h8000, byte base address of the screenbuffer.
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- FILL_CHAR, 8'h20, code written when clearing.

Ports:
- clk  input  1  bus-domain clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  character code.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- addr  output  32  bus byte address.
- wdata  output  32  bus write data.
- wmask  output  4  byte-lane enables.
- wen  output  1  bus write request.
- bus_ready  input  1  write completed (slave ready).
- cursor_col  output  7  current column, 0..COLS-1.
- cursor_row  output  5  current row, 0..ROWS-1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wen=0; addr=0, wdata=0, wmask=0.
  - cursor_col=0, cursor_row=0; in_ready=0 while reset is asserted.
  - Reset mid-transaction drops wen immediately. No partial write is retried.
- States: IDLE, WRITE, CLR_LINE, CLR_ALL.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, decode in_data (one char per handshake).
  - Printable (0x20..0x7E, and 0x80..0xFF): go to WRITE.
    - addr = BASE_ADDR + (row*COLS+col).
    - wmask = 4'b0001 << addr[1:0].
    - wdata = {4{char}}.
  - 0x0D (CR): col=0, stay IDLE.
  - 0x0A (LF): col=0, row advances (see line advance).
  - 0x08 (BS): col=col-1 if col>0, else no-op. Nothing is erased.
  - 0x0C (FF): go to CLR_ALL; cursor goes to (0,0) at entry.
  - Other control codes: ignored; the character is consumed.
- Bus handshake:
  - wen is asserted the cycle after acceptance.
  - addr, wdata and wmask are held stable while wen=1.
  - A write completes on a rising edge where wen&bus_ready. wen is low the following cycle (at least one idle cycle between writes).
  - No timeout; waits indefinitely.
- WRITE completion:
  - If col<COLS-1: col+1, return to IDLE.
  - Else: col=0 and line advance.
- Line advance:
  - row = (row==ROWS-1) ? 0 : row+1.
  - Then enter CLR_LINE for the new row.
- CLR_LINE:
  - COLS/4 sequential word writes.
  - addr = BASE_ADDR + row*COLS + 4k for k=0..COLS/4-1.
  - wmask=4'b1111, wdata={4{FILL_CHAR}}.
  - Then return to IDLE.
- CLR_ALL:
  - ROWS*COLS/4 word writes from BASE_ADDR upward, step 4, same data and mask as CLR_LINE.
  - Then return to IDLE with cursor at (0,0).
- Row 0 is not cleared at reset.
- Internal arithmetic:
  - Linear index width is 12 bits (max 2399).
  - Word counter width is 10 bits (max 599).
  - addr = BASE_ADDR + zero-extended index.
- COLS must be a multiple of 4. This is a build-time check.
- Cursor outputs are registered and update on the edge where the triggering event completes:
  - WRITE/LF/CR/BS: at completion.
  - FF: at acceptance.
- in_valid is ignored while busy. There is no buffering; the upstream holds data until in_ready.

Test Plan:
- After reset, send 'A' (0x41), bus_ready=1 → one write: addr=0x8000, wmask=0001, wdata=0x41414141. Cursor then (1,0); wen pulses for exactly 1 cycle.
- Send "ABCDE" with bus_ready delayed 3 cycles per write → 5th write at addr=0x8004, wmask=0001. addr/wdata stay stable during the wait; cursor ends at (5,0).
- 80 printable chars from (0,0) → 80 byte writes, then 20 word writes at 0x8050..0x809C with wmask=1111 and data 0x20202020. Cursor ends at (0,1); in_ready=0 during the clear.
- Cursor at row 29, send LF → clear writes at 0x8000+29*80+80 wrap to row 0 (0x8000..0x804C). Cursor ends at (0,0).
- Sequence 'X', BS, BS, 'Y' → 'Y' written at 0x8000 lane 0. The second BS at col 0 is a no-op; CR from col 5 gives col 0 with no bus activity.
- FF mid-screen → 600 word writes from 0x8000 to 0x895C, cursor (0,0). Assert rst during write #300 → wen drops asynchronously, cursor=0, state IDLE.
